// File: rtl/riscv_div_unit_if.sv
// Request/response bundle between the execute-stage control path and the divider.
interface riscv_div_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, op, a, b,
        input  busy, done, result
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result
    );
endinterface

// File: rtl/riscv_div_unit.sv
// RV32M DIV/DIVU/REM/REMU, radix-2 restoring; done 34 clocks after accept (2 for /0 and overflow).
// Requests arriving while busy are dropped; the requester holds start until busy is low.
module riscv_div_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    riscv_div_unit_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    state_t          state, state_nxt;
    logic [XLEN-1:0] dvd;
    logic [XLEN-1:0] dvs;
    logic [XLEN-1:0] rem;
    logic [CNT_W-1:0] cnt;
    logic            is_rem;
    logic            neg_q;
    logic            neg_r;
    logic            done;
    logic [XLEN-1:0] result;

    logic            signed_op;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            div_zero;
    logic            ovf;
    logic            accept;
    logic            last_iter;
    logic [XLEN:0]   rem_sh;
    logic [XLEN:0]   diff;

    assign signed_op = ~bus.op[0];
    assign a_neg     = signed_op & bus.a[XLEN-1];
    assign b_neg     = signed_op & bus.b[XLEN-1];
    // |INT_MIN| wraps to itself, which is the correct unsigned magnitude.
    assign a_mag     = a_neg ? -bus.a : bus.a;
    assign b_mag     = b_neg ? -bus.b : bus.b;
    assign div_zero  = (bus.b == '0);
    assign ovf       = signed_op && (bus.a == INT_MIN) && (bus.b == '1);
    assign accept    = (state == IDLE) && bus.start;
    assign last_iter = (cnt == CNT_W'(XLEN-1));

    assign rem_sh    = {rem, dvd[XLEN-1]};
    assign diff      = rem_sh - {1'b0, dvs};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.start) state_nxt = (div_zero || ovf) ? FIX : CALC;
            CALC: if (last_iter) state_nxt = FIX;
            FIX:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd    <= '0;
            dvs    <= '0;
            rem    <= '0;
            cnt    <= '0;
            is_rem <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            done <= (state == FIX);
            if (accept) begin
                is_rem <= bus.op[1];
                cnt    <= '0;
                // Special cases preload the final quotient/remainder so FIX handles them unchanged.
                if (div_zero) begin
                    dvd   <= '1;
                    rem   <= bus.a;
                    neg_q <= 1'b0;
                    neg_r <= 1'b0;
                end else if (ovf) begin
                    dvd   <= INT_MIN;
                    rem   <= '0;
                    neg_q <= 1'b0;
                    neg_r <= 1'b0;
                end else begin
                    dvd   <= a_mag;
                    dvs   <= b_mag;
                    rem   <= '0;
                    neg_q <= a_neg ^ b_neg;
                    neg_r <= a_neg;
                end
            end else if (state == CALC) begin
                cnt <= cnt + CNT_W'(1);
                if (!diff[XLEN]) begin
                    rem <= diff[XLEN-1:0];
                    dvd <= {dvd[XLEN-2:0], 1'b1};
                end else begin
                    rem <= rem_sh[XLEN-1:0];
                    dvd <= {dvd[XLEN-2:0], 1'b0};
                end
            end else if (state == FIX) begin
                if (is_rem) result <= neg_r ? -rem : rem;
                else        result <= neg_q ? -dvd : dvd;
            end
        end
    end

    assign bus.busy   = (state != IDLE);
    assign bus.done   = done;
    assign bus.result = result;
endmodule

// File: tb/tb_riscv_div_unit.sv
// Directed-vector bench for riscv_div_unit: results, latency, busy window, hazards, async reset.
module tb_riscv_div_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    riscv_div_unit_if #(.XLEN(32)) bus ();

    riscv_div_unit #(.XLEN(32), .CNT_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one request and waits for done; optionally injects a competing start at cycle hazard_at.
    task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int exp_lat, input string tag,
                       input int hazard_at);
        int lat;
        int busy_n;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        lat    = 1;
        busy_n = 0;
        while (!bus.done && lat < 100) begin
            if (bus.busy) busy_n++;
            if (lat == hazard_at) begin
                bus.op    = 2'b01;
                bus.a     = 32'd9;
                bus.b     = 32'd3;
                bus.start = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            tick();
            lat++;
        end
        bus.start = 1'b0;
        chk({tag, " done"},         32'(bus.done), 32'd1);
        chk({tag, " latency"},      32'(lat),      32'(exp_lat));
        chk({tag, " busy_cycles"},  32'(busy_n),   32'(exp_lat - 1));
        chk({tag, " busy_in_done"}, 32'(bus.busy), 32'd0);
        chk({tag, " result"},       bus.result,    exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int done_seen;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = '0;
        bus.b     = '0;
        #12;
        chk("reset busy",   32'(bus.busy), 32'd0);
        chk("reset done",   32'(bus.done), 32'd0);
        chk("reset result", bus.result,    32'd0);
        #10 rst_n = 1'b1;
        tick();

        run(2'b01, 32'd100, 32'd7, 32'd14, 34, "divu 100/7", -1);
        run(2'b11, 32'd100, 32'd7, 32'd2,  34, "remu 100/7", -1);
        tick();
        run(2'b00, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34, "div -7/2",  -1);
        run(2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34, "rem -7/2",  -1);
        run(2'b00, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 34, "div 7/-2",  -1);
        run(2'b00, 32'h80000000, 32'd2,        32'hC0000000, 34, "div min/2", -1);
        run(2'b10, 32'h80000000, 32'd3,        32'hFFFFFFFE, 34, "rem min/3", -1);
        run(2'b01, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 34, "divu max/1", -1);
        tick();
        run(2'b01, 32'd5,        32'd0,        32'hFFFFFFFF, 2, "divu 5/0",  -1);
        run(2'b10, 32'd5,        32'd0,        32'd5,        2, "rem 5/0",   -1);
        run(2'b00, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2, "div ovf",   -1);
        run(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0,        2, "rem ovf",   -1);
        tick();

        run(2'b01, 32'd1000, 32'd10, 32'd100, 34, "hazard divu", 10);
        run(2'b11, 32'd1000, 32'd7,  32'd6,   34, "b2b remu",    -1);
        tick();

        bus.op    = 2'b01;
        bus.a     = 32'd100;
        bus.b     = 32'd7;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (14) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("midreset busy",   32'(bus.busy), 32'd0);
        chk("midreset done",   32'(bus.done), 32'd0);
        chk("midreset result", bus.result,    32'd0);
        repeat (3) tick();
        #2 rst_n = 1'b1;
        done_seen = 0;
        repeat (40) begin
            tick();
            if (bus.done) done_seen++;
        end
        chk("postreset no_done", 32'(done_seen), 32'd0);
        chk("postreset result",  bus.result,     32'd0);
        run(2'b01, 32'd50, 32'd5, 32'd10, 34, "after reset divu", -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
